// File: rtl/wb_queue.sv
// wb_queue: 4-entry in-order writeback FIFO with youngest-match bypass.
// Define WBQ_BYPASS_EN to build the byp_* lookup; otherwise it is tied off.
module wb_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_vld,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        wb_rdy,
    input  logic        rf_gnt,
    output logic        rf_we,
    output logic [3:0]  rf_dst_addr,
    output logic [15:0] rf_dst,
    input  logic [3:0]  byp_addr,
    output logic        byp_hit,
    output logic [15:0] byp_data,
    output logic [2:0]  count,
    output logic        empty
);

    logic [3:0]  addr_q [4];
    logic [15:0] data_q [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  cnt;
    logic        enq;
    logic        deq;

    assign wb_rdy = (cnt < 3'd4);
    assign empty  = (cnt == 3'd0);
    assign count  = cnt;
    assign rf_we  = !empty;

    // R0 writes are accepted but never occupy an entry
    assign enq = wb_vld && wb_rdy && (wb_addr != 4'd0);
    assign deq = rf_we && rf_gnt;

    assign rf_dst_addr = empty ? 4'd0 : addr_q[rd_ptr];
    assign rf_dst      = empty ? 16'd0 : data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 3'd0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 2'd1;
            if (deq)
                rd_ptr <= rd_ptr + 2'd1;
            if (enq && !deq)
                cnt <= cnt + 3'd1;
            else if (deq && !enq)
                cnt <= cnt - 3'd1;
        end
    end

    // Storage is not reset; occupancy gating hides stale contents
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= wb_addr;
            data_q[wr_ptr] <= wb_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [1:0] idx;

    // Walk oldest to youngest so the last match wins
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = 16'd0;
        idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rd_ptr + 2'(i);
            if ((3'(i) < cnt) && (byp_addr != 4'd0) &&
                (addr_q[idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = data_q[idx];
            end
        end
    end
`else
    logic unused_byp;

    assign unused_byp = ^byp_addr;
    assign byp_hit    = 1'b0;
    assign byp_data   = 16'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue.
// Bypass checks follow WBQ_BYPASS_EN; otherwise byp_* must read 0.
module tb_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        wb_vld;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_rdy;
  logic        rf_gnt;
  logic        rf_we;
  logic [3:0]  rf_dst_addr;
  logic [15:0] rf_dst;
  logic [3:0]  byp_addr;
  logic        byp_hit;
  logic [15:0] byp_data;
  logic [2:0]  count;
  logic        empty;

  int n_chk;
  int n_fail;

  wb_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_vld      (wb_vld),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_rdy      (wb_rdy),
    .rf_gnt      (rf_gnt),
    .rf_we       (rf_we),
    .rf_dst_addr (rf_dst_addr),
    .rf_dst      (rf_dst),
    .byp_addr    (byp_addr),
    .byp_hit     (byp_hit),
    .byp_data    (byp_data),
    .count       (count),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [3:0] a,
                      input logic [15:0] d);
    chk({tag, " rf_we"}, rf_we === 1'b1);
    chk({tag, " addr"}, rf_dst_addr === a);
    chk({tag, " data"}, rf_dst === d);
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d);
    wb_vld  = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_vld  = 1'b0;
  endtask

  task automatic pop();
    rf_gnt = 1'b1;
    tick();
    rf_gnt = 1'b0;
  endtask

  task automatic byp(input string tag, input logic h,
                     input logic [15:0] d);
`ifdef WBQ_BYPASS_EN
    chk({tag, " byp_hit"}, byp_hit === h);
    chk({tag, " byp_data"}, byp_data === d);
`else
    chk({tag, " byp_hit off"}, byp_hit === 1'b0);
    chk({tag, " byp_data off"}, byp_data === 16'd0);
`endif
  endtask

  logic [3:0]  ea [12];
  logic [15:0] ed [12];

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    wb_vld   = 1'b0;
    wb_addr  = 4'd0;
    wb_data  = 16'd0;
    rf_gnt   = 1'b0;
    byp_addr = 4'd0;
    tick();
    tick();

    chk("rst count", count === 3'd0);
    chk("rst empty", empty === 1'b1);
    chk("rst rf_we", rf_we === 1'b0);
    chk("rst addr", rf_dst_addr === 4'd0);
    chk("rst data", rf_dst === 16'd0);
    chk("rst wb_rdy", wb_rdy === 1'b1);
    chk("rst byp_hit", byp_hit === 1'b0);
    chk("rst byp_data", byp_data === 16'd0);
    rst_n = 1'b1;

    push(4'd3, 16'hA5A5);
    head("enq1", 4'd3, 16'hA5A5);
    chk("enq1 count", count === 3'd1);
    pop();
    chk("enq1 drained", empty === 1'b1);
    chk("enq1 dst zero", rf_dst === 16'd0);

    for (int i = 0; i < 4; i++)
      push(4'(i + 1), 16'h1000 + 16'(i));
    chk("full count", count === 3'd4);
    chk("full wb_rdy", wb_rdy === 1'b0);
    push(4'd9, 16'h9999);
    chk("ovf count", count === 3'd4);
    head("ovf head", 4'd1, 16'h1000);
    rf_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain addr", rf_dst_addr === 4'(i + 1));
      chk("drain data", rf_dst === 16'h1000 + 16'(i));
      tick();
      if (i == 0)
        chk("unfull wb_rdy", wb_rdy === 1'b1);
    end
    rf_gnt = 1'b0;
    chk("drain empty", empty === 1'b1);
    chk("drain rf_we", rf_we === 1'b0);

    pop();
    chk("gnt empty count", count === 3'd0);

    push(4'd5, 16'h1111);
    push(4'd5, 16'h2222);
    byp_addr = 4'd5;
    #1;
    byp("dup2", 1'b1, 16'h2222);
    chk("dup count", count === 3'd2);
    pop();
    byp("dup1", 1'b1, 16'h2222);
    head("dup1 head", 4'd5, 16'h2222);
    pop();
    byp("dup0", 1'b0, 16'h0000);
    byp_addr = 4'd6;
    #1;
    byp("miss empty", 1'b0, 16'h0000);

    push(4'd7, 16'h0077);
    push(4'd0, 16'hFFFF);
    chk("r0 count", count === 3'd1);
    head("r0 head", 4'd7, 16'h0077);
    byp_addr = 4'd0;
    #1;
    byp("r0 byp", 1'b0, 16'h0000);
    byp_addr = 4'd7;
    #1;
    byp("r7 byp", 1'b1, 16'h0077);
    pop();

    for (int n = 0; n < 12; n++) begin
      ea[n] = 4'((n % 15) + 1);
      ed[n] = 16'hC000 + 16'(n);
    end
    push(ea[0], ed[0]);
    push(ea[1], ed[1]);
    for (int k = 0; k < 10; k++) begin
      chk("wrap pre addr", rf_dst_addr === ea[k]);
      chk("wrap pre data", rf_dst === ed[k]);
      wb_vld  = 1'b1;
      wb_addr = ea[k + 2];
      wb_data = ed[k + 2];
      rf_gnt  = 1'b1;
      tick();
      wb_vld  = 1'b0;
      rf_gnt  = 1'b0;
      chk("wrap count", count === 3'd2);
      byp_addr = ea[k + 2];
      #1;
      byp("wrap byp", 1'b1, ed[k + 2]);
    end
    head("wrap tail0", ea[10], ed[10]);
    pop();
    head("wrap tail1", ea[11], ed[11]);
    pop();
    chk("wrap empty", empty === 1'b1);

    push(4'd2, 16'h0202);
    push(4'd4, 16'h0404);
    push(4'd6, 16'h0606);
    chk("pre-rst count", count === 3'd3);
    rst_n   = 1'b0;
    wb_vld  = 1'b1;
    wb_addr = 4'd8;
    wb_data = 16'h0808;
    rf_gnt  = 1'b1;
    tick();
    rst_n   = 1'b1;
    wb_vld  = 1'b0;
    rf_gnt  = 1'b0;
    chk("midrst count", count === 3'd0);
    chk("midrst rf_we", rf_we === 1'b0);
    chk("midrst wb_rdy", wb_rdy === 1'b1);
    chk("midrst data", rf_dst === 16'd0);
    byp_addr = 4'd6;
    #1;
    byp("midrst byp", 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
